// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Reader side of the instruction memory interface. Owns the program counter,
//   drives a registered memory address, tracks the single outstanding read of a
//   1-cycle synchronous memory and buffers returned words in a small FIFO that
//   feeds the decode stage over a valid/ready handshake. Supports branch
//   redirect (flush) and halt.
//
// Ports:
//   i_clk              system clock, rising edge
//   i_rst_n            asynchronous active-low reset
//   i_start            pulse, begin fetching from current PC when idle
//   i_halt             level, stop issuing new fetches
//   i_redirect_valid   pulse, load PC with i_redirect_addr and flush
//   i_redirect_addr    redirect target
//   o_mem_addr         registered address to instruction memory
//   i_mem_instruction  read data, valid the cycle after o_mem_addr changes
//   o_instr_valid      buffer head valid
//   i_instr_ready      decode stage accepts head
//   o_instr_data       buffered instruction word
//   o_instr_pc         address the head word was fetched from
//   o_busy             fetching or draining
//   o_fetch_count      accepted-handshake counter (only with IFU_PERF_COUNT_EN)
//
// Build option:
//   IFU_PERF_COUNT_EN  adds the 16-bit saturating o_fetch_count output.
//
// States:
//   state | meaning
//   IDLE  | no fetches issued, waiting for start
//   FETCH | issue one fetch per cycle while buffer credit is available
//   DRAIN | halted, waiting for the outstanding read to return
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_halt,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_addr,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_instruction,
    output logic              o_instr_valid,
    input  logic              i_instr_ready,
    output logic [DATA_W-1:0] o_instr_data,
    output logic [ADDR_W-1:0] o_instr_pc,
    output logic              o_busy
`ifdef IFU_PERF_COUNT_EN
    ,
    output logic [15:0]       o_fetch_count
`endif
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_inflight;

    logic [DATA_W-1:0]  r_fifo_data [BUF_DEPTH];
    logic [ADDR_W-1:0]  r_fifo_pc   [BUF_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic [CNT_W-1:0]   w_occupancy;
    logic               w_credit;

    assign w_pop  = (r_count != '0) && i_instr_ready;
    // A response returning in a redirect cycle belongs to the old stream.
    assign w_push = r_inflight && !i_redirect_valid;

    // Occupancy counts the slot freed by a pop this cycle so a continuously
    // draining consumer sees one issue per cycle with only two entries.
    assign w_occupancy = r_count + CNT_W'(r_inflight) - CNT_W'(w_pop);
    assign w_credit    = (w_occupancy < CNT_W'(BUF_DEPTH));

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        if (i_redirect_valid) begin
            if (r_state == FETCH && i_halt) begin
                w_state_next = DRAIN;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start && !i_halt) begin
                        w_state_next = FETCH;
                    end
                end
                FETCH: begin
                    if (i_halt) begin
                        w_state_next = DRAIN;
                    end else begin
                        w_issue = w_credit;
                    end
                end
                DRAIN: begin
                    if (!r_inflight) begin
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc       <= '0;
            r_mem_addr <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (i_redirect_valid) begin
                r_pc <= i_redirect_addr;
            end else if (w_issue) begin
                r_pc       <= r_pc + 1'b1;
                r_mem_addr <= r_pc;
            end
        end
    end

    // The registered memory address doubles as the tag of the outstanding read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= i_mem_instruction;
                r_fifo_pc[r_wr_ptr]   <= r_mem_addr;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

`ifdef IFU_PERF_COUNT_EN
    logic [15:0] r_fetch_count;

    // A pop coinciding with a redirect is discarded, so it is not counted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_count <= '0;
        end else if (w_pop && !i_redirect_valid && r_fetch_count != 16'hFFFF) begin
            r_fetch_count <= r_fetch_count + 16'd1;
        end
    end

    assign o_fetch_count = r_fetch_count;
`endif

    assign o_mem_addr    = r_mem_addr;
    assign o_instr_valid = (r_count != '0);
    assign o_instr_data  = r_fifo_data[r_rd_ptr];
    assign o_instr_pc    = r_fifo_pc[r_rd_ptr];
    assign o_busy        = (r_state == FETCH) || (r_state == DRAIN);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              halt;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_instruction;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              busy;
`ifdef IFU_PERF_COUNT_EN
    logic [15:0]       fetch_count;
`endif

    int checks   = 0;
    int failures = 0;

    logic [ADDR_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    // Memory model: mem[i] = A000_0000 + i, read from the registered address.
    assign mem_instruction = 32'hA000_0000 + 32'(mem_addr);

    instruction_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .BUF_DEPTH(2)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .i_halt           (halt),
        .i_redirect_valid (redirect_valid),
        .i_redirect_addr  (redirect_addr),
        .o_mem_addr       (mem_addr),
        .i_mem_instruction(mem_instruction),
        .o_instr_valid    (instr_valid),
        .i_instr_ready    (instr_ready),
        .o_instr_data     (instr_data),
        .o_instr_pc       (instr_pc),
        .o_busy           (busy)
`ifdef IFU_PERF_COUNT_EN
        ,
        .o_fetch_count    (fetch_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Evaluate the handshake on current outputs, then advance to 1ns past the
    // next rising edge. A pop during a redirect is discarded and not scored.
    task automatic tick();
        logic [ADDR_W-1:0] e;
        if (instr_valid && instr_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected_pc", 32'(instr_pc), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", 32'(instr_pc), 32'(e));
                chk("pop_data", instr_data, 32'hA000_0000 + 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain_q(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        start          = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        instr_ready    = 1'b0;
        rst_n          = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset values ----------------
        do_reset();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
        chk("rst_instr_data", instr_data, 32'd0);
`ifdef IFU_PERF_COUNT_EN
        chk("rst_fetch_count", 32'(fetch_count), 32'd0);
`endif

        // ---------------- streaming with wrap ----------------
        instr_ready = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 9; i++) exp_q.push_back(ADDR_W'(i));
        tick();                                   // edge 0
        start = 1'b0;
        chk("lat_busy_e0", 32'(busy), 32'd1);
        chk("lat_valid_e0", 32'(instr_valid), 32'd0);
        tick();                                   // edge 1
        chk("lat_mem_addr_e1", 32'(mem_addr), 32'd0);
        chk("lat_valid_e1", 32'(instr_valid), 32'd0);
        tick();                                   // edge 2
        chk("lat_valid_e2", 32'(instr_valid), 32'd1);
        chk("lat_pc_e2", 32'(instr_pc), 32'd0);
        for (int i = 0; i < 9; i++) begin
            chk("stream_valid", 32'(instr_valid), 32'd1);
            tick();
        end
        chk("stream_left", 32'(exp_q.size()), 32'd0);

        // ---------------- async reset mid-stream ----------------
        instr_ready = 1'b0;
        repeat (3) tick();
        chk("pre_rst_valid", 32'(instr_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(instr_valid), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_idle_valid", 32'(instr_valid), 32'd0);
            chk("post_rst_idle_busy", 32'(busy), 32'd0);
        end

        // ---------------- backpressure ----------------
        do_reset();
        start = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(ADDR_W'(i));
        tick();                                   // edge 0
        start = 1'b0;
        repeat (3) tick();                        // edges 1..3
        chk("bp_mem_addr_a", 32'(mem_addr), 32'd1);
        repeat (2) tick();
        chk("bp_mem_addr_b", 32'(mem_addr), 32'd1);
        chk("bp_valid", 32'(instr_valid), 32'd1);
        chk("bp_pc", 32'(instr_pc), 32'd0);
        chk("bp_data", instr_data, 32'hA000_0000);
        instr_ready = 1'b1;
        drain_q(10);
        instr_ready = 1'b0;

        // ---------------- redirect ----------------
        do_reset();
        instr_ready = 1'b1;
        start = 1'b1;
        exp_q.push_back(ADDR_W'(0));
        tick();                                   // edge 0
        start = 1'b0;
        repeat (3) tick();                        // edges 1..3, pc 0 popped at 3
        chk("rd_queue_before", 32'(exp_q.size()), 32'd0);
        redirect_valid = 1'b1;
        redirect_addr  = 3'd5;
        for (int i = 5; i < 8; i++) exp_q.push_back(ADDR_W'(i));
        tick();                                   // edge 4: flush
        redirect_valid = 1'b0;
        chk("rd_flush_valid", 32'(instr_valid), 32'd0);
        chk("rd_busy", 32'(busy), 32'd1);
        tick();                                   // edge 5: issue 5
        chk("rd_valid_e5", 32'(instr_valid), 32'd0);
        chk("rd_mem_addr_e5", 32'(mem_addr), 32'd5);
        tick();                                   // edge 6: push 5
        chk("rd_first_pc", 32'(instr_pc), 32'd5);
        drain_q(6);
        instr_ready = 1'b0;

        // ---------------- halt and resume ----------------
        do_reset();
        instr_ready = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(ADDR_W'(i));
        tick();                                   // edge 0
        start = 1'b0;
        repeat (4) tick();                        // edges 1..4, pc 3 issued at 4
        chk("halt_mem_addr_3", 32'(mem_addr), 32'd3);
        halt = 1'b1;
        tick();                                   // edge 5
        chk("halt_drain_busy", 32'(busy), 32'd1);
        tick();                                   // edge 6
        chk("halt_idle_busy", 32'(busy), 32'd0);
        chk("halt_valid", 32'(instr_valid), 32'd0);
        chk("halt_left", 32'(exp_q.size()), 32'd0);
        start = 1'b1;                             // start with halt held: ignored
        tick();
        start = 1'b0;
        tick();
        chk("start_halt_busy", 32'(busy), 32'd0);
        chk("halt_mem_addr_hold", 32'(mem_addr), 32'd3);
        halt = 1'b0;
        start = 1'b1;
        exp_q.push_back(ADDR_W'(4));
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("resume_valid", 32'(instr_valid), 32'd1);
        chk("resume_pc", 32'(instr_pc), 32'd4);
        drain_q(4);
        instr_ready = 1'b0;

`ifdef IFU_PERF_COUNT_EN
        // ---------------- performance counter ----------------
        do_reset();
        instr_ready = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back(ADDR_W'(i));
        tick();
        start = 1'b0;
        drain_q(20);
        instr_ready = 1'b0;
        chk("perf_count_10", 32'(fetch_count), 32'd10);
        tick();
        redirect_valid = 1'b1;
        redirect_addr  = 3'd2;
        for (int i = 2; i < 5; i++) exp_q.push_back(ADDR_W'(i));
        tick();
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        drain_q(10);
        instr_ready = 1'b0;
        tick();
        chk("perf_count_13", 32'(fetch_count), 32'd13);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
